// File: rtl/types.sv
// Shared CPU datapath types: register selector encoding used by both the source mux
// and the writeback stage, plus the immediate-addressed selector resolution.
package types;

  typedef enum logic [4:0] {
    REG_A              = 5'd0,
    REG_B              = 5'd1,
    REG_TEMPA          = 5'd2,
    REG_TEMPB          = 5'd3,
    REG_XL             = 5'd4,
    REG_XH             = 5'd5,
    REG_XP             = 5'd6,
    REG_YL             = 5'd7,
    REG_YH             = 5'd8,
    REG_YP             = 5'd9,
    REG_SPL            = 5'd10,
    REG_SPH            = 5'd11,
    REG_FLAGS          = 5'd12,
    REG_MX             = 5'd13,
    REG_MY             = 5'd14,
    REG_MSP            = 5'd15,
    REG_MSP_INC        = 5'd16,
    REG_Mn             = 5'd17,
    REG_IMM_ADDR_L     = 5'd18,
    REG_IMM_ADDR_H     = 5'd19,
    REG_IMM_ADDR_P     = 5'd20,
    REG_ALU            = 5'd21,
    REG_ALU_WITH_FLAGS = 5'd22,
    REG_IMML           = 5'd23,
    REG_IMMH           = 5'd24,
    REG_HARDCODED_1    = 5'd25,
    REG_PCSL           = 5'd26,
    REG_PCSH           = 5'd27,
    REG_PCP            = 5'd28
  } reg_type;

  // imm[5:4] picks the group: 0 = RAM nibble Mn, 1 = X nibble, 2 = Y nibble,
  // 3 = {A, B, MX, MY} by imm[1:0]. The L/H/P variant picks the X/Y nibble.
  function automatic reg_type imm_addressed_reg(input reg_type sel, input logic [5:0] imm);
    reg_type res;
    res = sel;
    case (imm[5:4])
      2'b00: res = REG_Mn;
      2'b01: begin
        case (sel)
          REG_IMM_ADDR_L: res = REG_XL;
          REG_IMM_ADDR_H: res = REG_XH;
          default:        res = REG_XP;
        endcase
      end
      2'b10: begin
        case (sel)
          REG_IMM_ADDR_L: res = REG_YL;
          REG_IMM_ADDR_H: res = REG_YH;
          default:        res = REG_YP;
        endcase
      end
      default: begin
        case (imm[1:0])
          2'd0:    res = REG_A;
          2'd1:    res = REG_B;
          2'd2:    res = REG_MX;
          default: res = REG_MY;
        endcase
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Bundle between the datapath control and the writeback stage: commit controls in,
// architectural register values and the RAM write port out.
interface reg_writeback_if;
  import types::*;

  logic          clk_en;
  logic          write_en;
  reg_type       dest_sel;
  logic [7:0]    immed;
  logic [3:0]    data_in;
  logic          flags_we;
  logic [3:0]    flags_in;
  logic          inc_x;
  logic          inc_y;
  logic          sp_inc;
  logic          sp_dec;

  logic [3:0]    a;
  logic [3:0]    b;
  logic [3:0]    temp_a;
  logic [3:0]    temp_b;
  logic [11:0]   x;
  logic [11:0]   y;
  logic [7:0]    sp;
  logic [3:0]    flags;
  logic          memory_write_en;
  logic [11:0]   memory_write_addr;
  logic [3:0]    memory_write_data;

  modport master (
    output clk_en, write_en, dest_sel, immed, data_in, flags_we, flags_in,
           inc_x, inc_y, sp_inc, sp_dec,
    input  a, b, temp_a, temp_b, x, y, sp, flags,
           memory_write_en, memory_write_addr, memory_write_data
  );

  modport slave (
    input  clk_en, write_en, dest_sel, immed, data_in, flags_we, flags_in,
           inc_x, inc_y, sp_inc, sp_dec,
    output a, b, temp_a, temp_b, x, y, sp, flags,
           memory_write_en, memory_write_addr, memory_write_data
  );

endinterface

// File: rtl/reg_writeback.sv
// CPU writeback stage: owns A, B, TEMPA, TEMPB, X, Y, SP and F, commits the source-mux
// value to a register nibble or RAM nibble, and applies X/Y/SP pointer adjustments.
module reg_writeback
  import types::*;
(
  input  logic            clk,
  input  logic            reset,
  reg_writeback_if.slave  bus
);

  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [3:0]  temp_a_q, temp_a_d;
  logic [3:0]  temp_b_q, temp_b_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [7:0]  sp_q, sp_d;
  logic [3:0]  flags_q, flags_d;
  logic        mem_we_q, mem_we_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_data_q, mem_data_d;

  reg_type     eff_sel;
  logic        commit;
  logic        wr_x;
  logic        wr_y;
  logic        wr_sp;
  logic        mem_hit;
  logic        unused_immed_hi;

  assign unused_immed_hi = ^bus.immed[7:6];

  always_comb begin
    eff_sel = bus.dest_sel;
    if (bus.dest_sel inside {REG_IMM_ADDR_L, REG_IMM_ADDR_H, REG_IMM_ADDR_P}) begin
      eff_sel = imm_addressed_reg(bus.dest_sel, bus.immed[5:0]);
    end
  end

  // A write to any nibble of a pointer suppresses that pointer's whole adjustment.
  assign commit = bus.clk_en & bus.write_en;
  assign wr_x   = commit & (eff_sel inside {REG_XL, REG_XH, REG_XP});
  assign wr_y   = commit & (eff_sel inside {REG_YL, REG_YH, REG_YP});
  assign wr_sp  = commit & (eff_sel inside {REG_SPL, REG_SPH});

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
    a_d        = a_q;
    b_d        = b_q;
    temp_a_d   = temp_a_q;
    temp_b_d   = temp_b_q;
    x_d        = x_q;
    y_d        = y_q;
    sp_d       = sp_q;
    flags_d    = flags_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_hit    = 1'b0;
    mem_we_d   = 1'b0;

    if (bus.clk_en) begin
      if (bus.inc_x && !wr_x) x_d[7:0] = x_q[7:0] + 8'h01;
      if (bus.inc_y && !wr_y) y_d[7:0] = y_q[7:0] + 8'h01;
      if (!wr_sp) begin
        if (bus.sp_inc && !bus.sp_dec)      sp_d = sp_q + 8'h01;
        else if (bus.sp_dec && !bus.sp_inc) sp_d = sp_q - 8'h01;
      end
      if (bus.flags_we) flags_d = bus.flags_in;

      // Explicit writes come last so they override adjustments and flags_we.
      if (bus.write_en) begin
        case (eff_sel)
          REG_A:       a_d          = bus.data_in;
          REG_B:       b_d          = bus.data_in;
          REG_TEMPA:   temp_a_d     = bus.data_in;
          REG_TEMPB:   temp_b_d     = bus.data_in;
          REG_XL:      x_d[3:0]     = bus.data_in;
          REG_XH:      x_d[7:4]     = bus.data_in;
          REG_XP:      x_d[11:8]    = bus.data_in;
          REG_YL:      y_d[3:0]     = bus.data_in;
          REG_YH:      y_d[7:4]     = bus.data_in;
          REG_YP:      y_d[11:8]    = bus.data_in;
          REG_SPL:     sp_d[3:0]    = bus.data_in;
          REG_SPH:     sp_d[7:4]    = bus.data_in;
          REG_FLAGS:   flags_d      = bus.data_in;
          REG_MX: begin
            mem_hit    = 1'b1;
            mem_addr_d = x_q;
          end
          REG_MY: begin
            mem_hit    = 1'b1;
            mem_addr_d = y_q;
          end
          REG_MSP: begin
            mem_hit    = 1'b1;
            mem_addr_d = {4'h0, sp_q};
          end
          REG_MSP_INC: begin
            mem_hit    = 1'b1;
            mem_addr_d = {4'h0, sp_q + 8'h01};
          end
          REG_Mn: begin
            mem_hit    = 1'b1;
            mem_addr_d = {8'h00, bus.immed[3:0]};
          end
          default: ;
        endcase
      end
    end

    // Addresses use the pre-edge pointer values, so LDPX-style writes hit the old X/Y.
    if (mem_hit) begin
      mem_we_d   = 1'b1;
      mem_data_d = bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears every flop here, including a pending write strobe.
    if (reset) begin
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      temp_a_q   <= 4'h0;
      temp_b_q   <= 4'h0;
      x_q        <= 12'h000;
      y_q        <= 12'h000;
      sp_q       <= 8'h00;
      flags_q    <= 4'h0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 12'h000;
      mem_data_q <= 4'h0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      a_q        <= a_d;
      b_q        <= b_d;
      temp_a_q   <= temp_a_d;
      temp_b_q   <= temp_b_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sp_q       <= sp_d;
      flags_q    <= flags_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign bus.a                 = a_q;
  assign bus.b                 = b_q;
  assign bus.temp_a            = temp_a_q;
  assign bus.temp_b            = temp_b_q;
  assign bus.x                 = x_q;
  assign bus.y                 = y_q;
  assign bus.sp                = sp_q;
  assign bus.flags             = flags_q;
  assign bus.memory_write_en   = mem_we_q;
  assign bus.memory_write_addr = mem_addr_q;
  assign bus.memory_write_data = mem_data_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: a behavioural model predicts register state and RAM
// writes per cycle; a monitor compares DUT outputs after each clock edge.
module tb_reg_writeback;
  import types::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_writeback_if bus ();

  reg_writeback dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit rst, ce, we;
    int sel, imm, din;
    bit fwe;
    int fin;
    bit ix, iy, si, sd;
  } stim_t;

  typedef struct {
    int a, b, ta, tb, f, x, y, sp, we, addr, data;
  } snap_t;

  typedef struct {
    int addr, data;
  } mem_t;

  snap_t exp_q[$];
  mem_t  mem_q[$];

  int m_a, m_b, m_ta, m_tb, m_f, m_x, m_y, m_sp, m_we, m_addr, m_data;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate-addressed selectors: group by imm/16, variant by distance from IMM_ADDR_L.
  function automatic int ref_resolve(input int sel, input int imm6);
    int grp, off;
    int tbl[4];
    tbl = '{int'(REG_A), int'(REG_B), int'(REG_MX), int'(REG_MY)};
    if (sel < int'(REG_IMM_ADDR_L) || sel > int'(REG_IMM_ADDR_P)) return sel;
    grp = imm6 / 16;
    off = sel - int'(REG_IMM_ADDR_L);
    if (grp == 0) return int'(REG_Mn);
    if (grp == 1) return int'(REG_XL) + off;
    if (grp == 2) return int'(REG_YL) + off;
    return tbl[imm6 % 4];
  endfunction

  task automatic model_step(input stim_t s);
    int t, nx, ny, nsp, nf;
    bit mem;
    int maddr;
    if (s.rst) begin
      m_a = 0; m_b = 0; m_ta = 0; m_tb = 0; m_f = 0;
      m_x = 0; m_y = 0; m_sp = 0; m_we = 0; m_addr = 0; m_data = 0;
      return;
    end
    m_we = 0;
    if (!s.ce) return;
    t = s.we ? ref_resolve(s.sel, s.imm % 64) : -1;
    nx = m_x; ny = m_y; nsp = m_sp; nf = m_f;
    if (s.ix && !(t >= int'(REG_XL) && t <= int'(REG_XP)))
      nx = (m_x / 256) * 256 + (m_x % 256 + 1) % 256;
    if (s.iy && !(t >= int'(REG_YL) && t <= int'(REG_YP)))
      ny = (m_y / 256) * 256 + (m_y % 256 + 1) % 256;
    if (!(t == int'(REG_SPL) || t == int'(REG_SPH))) begin
      if (s.si && !s.sd) nsp = (m_sp + 1) % 256;
      if (s.sd && !s.si) nsp = (m_sp + 255) % 256;
    end
    if (s.fwe) nf = s.fin;
    mem = 0;
    maddr = 0;
    case (t)
      int'(REG_A):       m_a  = s.din;
      int'(REG_B):       m_b  = s.din;
      int'(REG_TEMPA):   m_ta = s.din;
      int'(REG_TEMPB):   m_tb = s.din;
      int'(REG_XL):      nx   = (m_x / 16) * 16 + s.din;
      int'(REG_XH):      nx   = (m_x / 256) * 256 + s.din * 16 + m_x % 16;
      int'(REG_XP):      nx   = s.din * 256 + m_x % 256;
      int'(REG_YL):      ny   = (m_y / 16) * 16 + s.din;
      int'(REG_YH):      ny   = (m_y / 256) * 256 + s.din * 16 + m_y % 16;
      int'(REG_YP):      ny   = s.din * 256 + m_y % 256;
      int'(REG_SPL):     nsp  = (m_sp / 16) * 16 + s.din;
      int'(REG_SPH):     nsp  = s.din * 16 + m_sp % 16;
      int'(REG_FLAGS):   nf   = s.din;
      int'(REG_MX):      begin mem = 1; maddr = m_x; end
      int'(REG_MY):      begin mem = 1; maddr = m_y; end
      int'(REG_MSP):     begin mem = 1; maddr = m_sp; end
      int'(REG_MSP_INC): begin mem = 1; maddr = (m_sp + 1) % 256; end
      int'(REG_Mn):      begin mem = 1; maddr = s.imm % 16; end
      default: ;
    endcase
    if (mem) begin
      m_we = 1; m_addr = maddr; m_data = s.din;
      mem_q.push_back('{addr: maddr, data: s.din});
    end
    m_x = nx; m_y = ny; m_sp = nsp; m_f = nf;
  endtask

  task automatic drive(input stim_t s);
    logic [4:0] sel5;
    @(negedge clk);
    sel5 = s.sel[4:0];
    reset        = s.rst;
    bus.clk_en   = s.ce;
    bus.write_en = s.we;
    bus.dest_sel = reg_type'(sel5);
    bus.immed    = s.imm[7:0];
    bus.data_in  = s.din[3:0];
    bus.flags_we = s.fwe;
    bus.flags_in = s.fin[3:0];
    bus.inc_x    = s.ix;
    bus.inc_y    = s.iy;
    bus.sp_inc   = s.si;
    bus.sp_dec   = s.sd;
    model_step(s);
    exp_q.push_back('{a: m_a, b: m_b, ta: m_ta, tb: m_tb, f: m_f, x: m_x, y: m_y,
                      sp: m_sp, we: m_we, addr: m_addr, data: m_data});
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.ce = 1'b1;
    return s;
  endfunction

  function automatic stim_t wr(input reg_type sel, input int din);
    stim_t s;
    s = idle();
    s.we = 1'b1;
    s.sel = int'(sel);
    s.din = din;
    return s;
  endfunction

  // Lands just after the edge that consumed the last driven stimulus.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    snap_t s;
    mem_t  m;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        s = exp_q.pop_front();
        check("a",      32'(bus.a),      s.a);
        check("b",      32'(bus.b),      s.b);
        check("temp_a", 32'(bus.temp_a), s.ta);
        check("temp_b", 32'(bus.temp_b), s.tb);
        check("flags",  32'(bus.flags),  s.f);
        check("x",      32'(bus.x),      s.x);
        check("y",      32'(bus.y),      s.y);
        check("sp",     32'(bus.sp),     s.sp);
        check("mem_we", 32'(bus.memory_write_en), s.we);
        check("mem_addr_hold", 32'(bus.memory_write_addr), s.addr);
        if (s.we != 0 && mem_q.size() != 0) begin
          m = mem_q.pop_front();
          check("mem_addr", 32'(bus.memory_write_addr), m.addr);
          check("mem_data", 32'(bus.memory_write_data), m.data);
        end
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    bus.clk_en = 1'b0; bus.write_en = 1'b0; bus.dest_sel = REG_A; bus.immed = 8'h00;
    bus.data_in = 4'h0; bus.flags_we = 1'b0; bus.flags_in = 4'h0;
    bus.inc_x = 1'b0; bus.inc_y = 1'b0; bus.sp_inc = 1'b0; bus.sp_dec = 1'b0;

    s = '{default: 0}; s.rst = 1'b1;
    drive(s); settle();
    check("rst_x", 32'(bus.x), 32'h000);
    check("rst_sp", 32'(bus.sp), 32'h00);
    check("rst_flags", 32'(bus.flags), 32'h0);
    check("rst_mem_we", 32'(bus.memory_write_en), 32'h0);

    drive(wr(REG_XH, 4'hA)); settle();
    check("xh_write", 32'(bus.x), 32'h0A0);
    s = wr(REG_XH, 4'h5); s.ce = 1'b0;
    drive(s); settle();
    check("xh_write_clk_en0", 32'(bus.x), 32'h0A0);

    drive(wr(REG_XL, 4'hF));
    drive(wr(REG_XH, 4'hF));
    drive(wr(REG_XP, 4'h3));
    s = wr(REG_MX, 4'h5); s.ix = 1'b1;
    drive(s); settle();
    check("ldpx_strobe", 32'(bus.memory_write_en), 32'h1);
    check("ldpx_addr", 32'(bus.memory_write_addr), 32'h3FF);
    check("ldpx_data", 32'(bus.memory_write_data), 32'h5);
    check("ldpx_x_wrap", 32'(bus.x), 32'h300);
    drive(idle()); settle();
    check("strobe_one_cycle", 32'(bus.memory_write_en), 32'h0);
    check("addr_hold", 32'(bus.memory_write_addr), 32'h3FF);

    s = idle(); s.sd = 1'b1;
    drive(s); settle();
    check("sp_dec_wrap", 32'(bus.sp), 32'hFF);
    s = idle(); s.si = 1'b1; s.sd = 1'b1;
    drive(s); settle();
    check("sp_inc_dec", 32'(bus.sp), 32'hFF);
    drive(wr(REG_MSP_INC, 4'h9)); settle();
    check("msp_inc_addr", 32'(bus.memory_write_addr), 32'h000);
    check("msp_inc_strobe", 32'(bus.memory_write_en), 32'h1);

    drive(wr(REG_SPH, 4'h2));
    drive(wr(REG_SPL, 4'hF));
    s = wr(REG_SPL, 4'h7); s.si = 1'b1;
    drive(s); settle();
    check("spl_beats_inc", 32'(bus.sp), 32'h27);

    drive(wr(REG_IMML, 4'hC)); settle();
    check("imml_no_strobe", 32'(bus.memory_write_en), 32'h0);
    check("imml_sp", 32'(bus.sp), 32'h27);
    check("imml_a", 32'(bus.a), 32'h0);

    s = wr(REG_IMM_ADDR_L, 4'h3); s.imm = 8'h0C;
    drive(s); settle();
    check("imm_mn_strobe", 32'(bus.memory_write_en), 32'h1);
    check("imm_mn_addr", 32'(bus.memory_write_addr), 32'h00C);

    s = wr(REG_MY, 4'h6); s.rst = 1'b1;
    drive(s); settle();
    check("rst_blocks_strobe", 32'(bus.memory_write_en), 32'h0);
    check("rst_blocks_addr", 32'(bus.memory_write_addr), 32'h000);
    drive(wr(REG_MSP, 4'h2));
    s = idle(); s.rst = 1'b1;
    drive(s); settle();
    check("rst_clears_pending", 32'(bus.memory_write_en), 32'h0);

    for (int i = 0; i < 600; i++) begin
      s.rst = ($urandom_range(0, 63) == 0);
      s.ce  = ($urandom_range(0, 3) != 0);
      s.we  = ($urandom_range(0, 3) != 0);
      s.sel = int'($urandom_range(0, 31));
      s.imm = int'($urandom_range(0, 255));
      s.din = int'($urandom_range(0, 15));
      s.fwe = $urandom_range(0, 1) != 0;
      s.fin = int'($urandom_range(0, 15));
      s.ix  = $urandom_range(0, 1) != 0;
      s.iy  = $urandom_range(0, 1) != 0;
      s.si  = $urandom_range(0, 2) == 0;
      s.sd  = $urandom_range(0, 2) == 0;
      drive(s);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Destination stage of the CPU datapath: consumes the 4-bit value chosen by the source register mux and commits it to the selected destination. Destinations are a CPU register nibble, a temp register, or a RAM nibble. Owns the architectural state A, B, TEMPA, TEMPB, X, Y, SP and F, and feeds those values back to the source mux. Also applies post-increment of X/Y and push/pop adjustment of SP, and issues registered single-cycle RAM write strobes.

## Interface
Parameters:
- none (widths fixed by the `types` package and the CPU architecture)

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high; one clock, one reset, no other clock domains
- `clk_en`  in  1  CPU cycle enable; architectural state advances only on enabled edges
- `write_en`  in  1  commit `data_in` to `dest_sel` on this enabled edge
- `dest_sel`  in  `reg_type`  destination selector (same encoding as the source mux)
- `immed`  in  8  current instruction immediate; `immed[5:0]` resolves REG_IMM_ADDR_*, `immed[3:0]` addresses REG_Mn
- `data_in`  in  4  value from the source mux `out`
- `flags_we`  in  1  load F from `flags_in`
- `flags_in`  in  4  new flags {I,D,Z,C}
- `inc_x`, `inc_y`  in  1  post-increment X[7:0] / Y[7:0]
- `sp_inc`, `sp_dec`  in  1  SP +1 / −1
- `a`, `b`, `temp_a`, `temp_b`  out  4  register values
- `x`, `y`  out  12  index registers {P,H,L}
- `sp`  out  8  stack pointer
- `flags`  out  4  F register
- `memory_write_en`  out  1  RAM write strobe
- `memory_write_addr`  out  12  RAM nibble address
- `memory_write_data`  out  4  RAM write data

## Operation
- Selector resolution:
  - REG_IMM_ADDR_L/H/P resolve through `imm_addressed_reg(dest_sel, immed[5:0])`.
  - All other selectors are used directly.
- Register destinations, on `clk_en & write_en`:
  - REG_A, REG_B, REG_TEMPA, REG_TEMPB load `data_in`.
  - REG_XL/XH/XP load x[3:0]/x[7:4]/x[11:8]; Y likewise.
  - REG_SPL/SPH load sp[3:0]/sp[7:4].
  - REG_FLAGS loads F.
- Memory destinations, on `clk_en & write_en`; addresses are formed from register values before this edge's updates:
  - REG_MX → address x.
  - REG_MY → address y.
  - REG_MSP → address {4'h0, sp}.
  - REG_MSP_INC → address {4'h0, sp+8'h1}, wrapping in 8 bits.
  - REG_Mn → address {8'h00, immed[3:0]}.
- Non-writable destinations (REG_ALU*, REG_IMML/H, REG_HARDCODED_1, REG_PC*, unused codes): write silently dropped, no state change, no strobe.
- X/Y post-increment: `inc_x` sets x[7:0] ← x[7:0]+1 with wrap 8'hFF→8'h00; x[11:8] unchanged. `inc_y` is the same for Y.
- SP adjust: `sp_inc` → sp+1, `sp_dec` → sp−1, both 8-bit wrap; both asserted → no change.
- Flags:
  - `flags_we` loads `flags_in`.
  - If `flags_we` and a REG_FLAGS write occur together, the REG_FLAGS write wins.
- Priority on the same register nibble:
  - An explicit `data_in` write beats increment/decrement.
  - If `write_en` targets XL/XH/XP while `inc_x`=1, the write is applied and the whole increment is dropped. Same rule for Y and SP.
- Increment plus a memory write through the same pointer (e.g. REG_MX + `inc_x`): memory uses the old X; X increments. This is the LDPX/LBPX behaviour.

## Timing
- Reset values, taking effect on the reset edge regardless of `clk_en`:
  - a, b, temp_a, temp_b, flags = 4'h0
  - x, y = 12'h000
  - sp = 8'h00
  - memory_write_en = 0, memory_write_addr = 12'h000, memory_write_data = 4'h0
- Register destinations: new value visible on outputs one clock after the enabled commit edge (registered outputs, no combinational path from `data_in`).
- Memory writes:
  - Address and data register on the commit edge.
  - `memory_write_en` is high for exactly one `clk` cycle after that edge, independent of `clk_en`, then deasserts.
  - Address and data hold until the next memory commit.
- `clk_en`=0: all state and `write_en`/inc/dec inputs ignored; only the strobe self-clears.
- Reset asserted while a strobe is pending: strobe clears on that edge, and no write is issued afterwards.

## Test plan
- Reset with `clk_en`=0 → all outputs at the reset values above on the next clock.
- Write 4'hA to REG_XH with `clk_en`=1 → x=12'h0A0 the next cycle. Repeat with `clk_en`=0 → x unchanged.
- x=12'h3FF, REG_MX write of 4'h5 with `inc_x` → one-cycle strobe with addr 12'h3FF, data 4'h5; then x=12'h300.
- sp=8'h00:
  - `sp_dec` → sp=8'hFF.
  - `sp_inc`+`sp_dec` together → no change.
  - REG_MSP_INC write at sp=8'hFF → addr 12'h000.
- REG_SPL write of 4'h7 with `sp_inc`, sp=8'h2F → sp=8'h27.
- Non-writable destination: REG_IMML with `write_en` → no state change, `memory_write_en` stays 0.
- REG_IMM_ADDR_L resolving to the Mn path, immed=8'h0C → strobe at addr 12'h00C.
- Reset asserted on the cycle the strobe would fire → strobe never seen.
